// File: rtl/tick_timer_ctrl.sv
// tick_timer_ctrl: prescaled tick generator with start/pause/stop control and a loadable down-counter
module tick_timer_ctrl #(
  parameter int CLK_HZ  = 50_000_000,
  parameter int TICK_HZ = 1,
  parameter int CNT_W   = 16
) (
  input  logic             clk_50mhz,
  input  logic             reset,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_load,
  input  logic             cfg_periodic,
  input  logic             start,
  input  logic             pause,
  input  logic             stop,
  output logic             tick,
  output logic             done,
  output logic [CNT_W-1:0] remaining,
  output logic [1:0]       state,
  output logic             busy
);
  localparam int DIV = CLK_HZ / TICK_HZ;
  localparam int PW = (DIV > 2) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PMAX = PW'(DIV - 1);
  localparam logic [1:0] IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2;

  if (DIV < 2) begin : g_bad_div
    $error("tick_timer_ctrl: CLK_HZ/TICK_HZ must be at least 2");
  end

  logic [PW-1:0]    pre;
  logic [CNT_W-1:0] reload;
  logic             periodic;
  logic [1:0]       state_next;
  logic             hs, wrap, last, go;

  assign hs   = cfg_valid & cfg_ready;
  assign wrap = (state == RUN) && (pre == PMAX);
  assign last = wrap && (remaining == CNT_W'(1));
  assign go   = start && !hs && (reload != '0);

  // state register
  always_ff @(posedge clk_50mhz)
    state <= reset ? IDLE : state_next;

  // next-state: stop wins, a one-shot terminal wrap overrides pause
  always_comb begin
    state_next = state;
    if (stop) state_next = IDLE;
    else if (state == IDLE) state_next = go ? RUN : IDLE;
    else if (state == RUN) state_next = (last && !periodic) ? IDLE : pause ? PAUSE : RUN;
    else if (state == PAUSE) state_next = start ? RUN : PAUSE;
    else state_next = IDLE;
  end

  // status outputs decoded from state
  always_comb begin
    cfg_ready = (state == IDLE);
    busy      = (state != IDLE);
  end

  // prescaler, tick/done strobes, remaining count and captured configuration
  always_ff @(posedge clk_50mhz) begin
    if (reset) begin
      pre       <= '0;
      tick      <= 1'b0;
      done      <= 1'b0;
      remaining <= '0;
      reload    <= '0;
      periodic  <= 1'b0;
    end else begin
      tick <= 1'b0;
      done <= 1'b0;
      if (stop) begin
        pre       <= '0;
        remaining <= reload;
      end else if (state == IDLE) begin
        if (hs) begin
          reload    <= cfg_load;
          remaining <= cfg_load;
          periodic  <= cfg_periodic;
        end else if (go) begin
          pre <= '0;
          if (remaining == '0) remaining <= reload;
        end
      end else if (state == RUN && (wrap || !pause)) begin
        pre <= wrap ? '0 : pre + 1'b1;
        if (wrap) begin
          tick      <= 1'b1;
          done      <= last;
          remaining <= last ? (periodic ? reload : '0) : remaining - 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_tick_timer_ctrl.sv
// tb_tick_timer_ctrl: directed scenarios with a tick scoreboard for tick_timer_ctrl
module tb_tick_timer_ctrl;
  logic       clk_50mhz = 1'b0;
  logic       reset = 1'b1;
  logic       cfg_valid = 1'b0, cfg_periodic = 1'b0, start = 1'b0, pause = 1'b0, stop = 1'b0;
  logic [7:0] cfg_load = '0;
  logic       cfg_ready, tick, done, busy;
  logic [7:0] remaining;
  logic [1:0] state;

  typedef struct {int c; int rem; int dn; int st;} exp_t;
  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   s;

  tick_timer_ctrl #(.CLK_HZ(10), .TICK_HZ(1), .CNT_W(8)) dut (
    .clk_50mhz(clk_50mhz), .reset(reset), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_load(cfg_load), .cfg_periodic(cfg_periodic), .start(start), .pause(pause), .stop(stop),
    .tick(tick), .done(done), .remaining(remaining), .state(state), .busy(busy)
  );

  always #5 clk_50mhz = ~clk_50mhz;
  always @(posedge clk_50mhz) cyc <= cyc + 1;

  task automatic chk(input string n, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s got %0d expected %0d at cycle %0d", n, a, e, cyc);
    end
  endtask

  task automatic push(input int c, input int rem, input int dn, input int st);
    exp_t e;
    e.c = c; e.rem = rem; e.dn = dn; e.st = st;
    q.push_back(e);
  endtask

  task automatic cfg(input int load, input logic per);
    cfg_valid = 1'b1; cfg_load = 8'(load); cfg_periodic = per;
    @(negedge clk_50mhz);
    cfg_valid = 1'b0;
  endtask

  task automatic do_start(output int se);
    start = 1'b1;
    se = cyc + 1;
    @(negedge clk_50mhz);
    start = 1'b0;
  endtask

  task automatic wait_to(input int t);
    while (cyc < t) @(negedge clk_50mhz);
  endtask

  // monitor: every tick pops the scoreboard; missed or stray strobes are errors
  always @(negedge clk_50mhz) begin
    if (q.size() > 0 && cyc > q[0].c) begin
      checks++; errors++;
      $display("FAIL tick_missed got none expected tick at cycle %0d (now %0d)", q[0].c, cyc);
      void'(q.pop_front());
    end
    if (tick) begin
      if (q.size() == 0) begin
        checks++; errors++;
        $display("FAIL tick_unexpected got tick expected none at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("tick_cycle", cyc, e.c);
        chk("tick_remaining", remaining, e.rem);
        chk("tick_done", done, e.dn);
        chk("tick_state", state, e.st);
        chk("tick_busy", busy, e.st != 0);
      end
    end else if (done) begin
      checks++; errors++;
      $display("FAIL done_without_tick got done=1 expected 0 at cycle %0d", cyc);
    end
  end

  initial begin
    repeat (2) @(negedge clk_50mhz);
    chk("rst_state", state, 0);
    chk("rst_remaining", remaining, 0);
    chk("rst_cfg_ready", cfg_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_tick", tick, 0);
    chk("rst_done", done, 0);
    reset = 1'b0;
    @(negedge clk_50mhz);

    // one-shot load 3
    cfg(3, 1'b0);
    chk("t1_loaded", remaining, 3);
    do_start(s);
    chk("t1_run", state, 1);
    chk("t1_busy", busy, 1);
    chk("t1_cfg_ready", cfg_ready, 0);
    push(s + 10, 2, 0, 1); push(s + 20, 1, 0, 1); push(s + 30, 0, 1, 0);
    wait_to(s + 32);
    chk("t1_idle", state, 0);
    chk("t1_rem0", remaining, 0);

    // periodic load 2, stop at start+45
    cfg(2, 1'b1);
    do_start(s);
    push(s + 10, 1, 0, 1); push(s + 20, 2, 1, 1); push(s + 30, 1, 0, 1); push(s + 40, 2, 1, 1);
    wait_to(s + 44);
    stop = 1'b1;
    @(negedge clk_50mhz);
    stop = 1'b0;
    chk("t2_stop_state", state, 0);
    chk("t2_stop_rem", remaining, 2);
    wait_to(s + 70);

    // pause at start+4, resume at start+10 -> tick at start+17
    cfg(5, 1'b0);
    do_start(s);
    push(s + 17, 4, 0, 1);
    wait_to(s + 3);
    pause = 1'b1;
    @(negedge clk_50mhz);
    pause = 1'b0;
    chk("t3_paused", state, 2);
    wait_to(s + 8);
    chk("t3_pause_hold", state, 2);
    chk("t3_pause_rem", remaining, 5);
    wait_to(s + 9);
    start = 1'b1;
    @(negedge clk_50mhz);
    start = 1'b0;
    chk("t3_resumed", state, 1);
    wait_to(s + 19);
    stop = 1'b1;
    @(negedge clk_50mhz);
    stop = 1'b0;
    chk("t3_stop_rem", remaining, 5);

    // cfg during RUN refused; start with cfg ignored; load 0 cannot start
    cfg(4, 1'b0);
    do_start(s);
    push(s + 10, 3, 0, 1);
    wait_to(s + 2);
    cfg_valid = 1'b1; cfg_load = 8'd9;
    chk("t4_cfg_ready_run", cfg_ready, 0);
    @(negedge clk_50mhz);
    cfg_valid = 1'b0;
    wait_to(s + 11);
    stop = 1'b1;
    @(negedge clk_50mhz);
    stop = 1'b0;
    chk("t4_reload_kept", remaining, 4);
    cfg_valid = 1'b1; cfg_load = 8'd2; start = 1'b1;
    @(negedge clk_50mhz);
    cfg_valid = 1'b0; start = 1'b0;
    chk("t4_start_with_cfg", state, 0);
    chk("t4_cfg_taken", remaining, 2);
    cfg(0, 1'b0);
    chk("t4_zero_load", remaining, 0);
    do_start(s);
    wait_to(s + 15);
    chk("t4_zero_idle", state, 0);

    // stop vs pause on the terminal wrap of a one-shot load 1
    cfg(1, 1'b0);
    do_start(s);
    wait_to(s + 9);
    stop = 1'b1;
    @(negedge clk_50mhz);
    stop = 1'b0;
    chk("t5_stop_tick", tick, 0);
    chk("t5_stop_done", done, 0);
    chk("t5_stop_state", state, 0);
    chk("t5_stop_rem", remaining, 1);
    do_start(s);
    push(s + 10, 0, 1, 0);
    wait_to(s + 9);
    pause = 1'b1;
    @(negedge clk_50mhz);
    pause = 1'b0;
    wait_to(s + 12);
    chk("t5_pause_idle", state, 0);

    // reset mid periodic run
    cfg(3, 1'b1);
    do_start(s);
    push(s + 10, 2, 0, 1);
    wait_to(s + 12);
    reset = 1'b1;
    @(negedge clk_50mhz);
    reset = 1'b0;
    chk("t6_state", state, 0);
    chk("t6_rem", remaining, 0);
    chk("t6_tick", tick, 0);
    chk("t6_done", done, 0);
    chk("t6_cfg_ready", cfg_ready, 1);
    wait_to(s + 40);

    chk("scoreboard_empty", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
